// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   arb_state_t : IDLE (1'b0) / GRANT (1'b1) encoding
//   N_REQ, IDX_W : requester count and grant index width
//   MAX_HOLD_DEF : default hold limit for the optional timeout feature
//   rr_pick()    : round-robin priority search starting after last_ptr
package arb_pkg;

  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Search order is last_ptr+1, +2, +3, then last_ptr itself (mod N_REQ).
  // The loop walks from the farthest candidate to the nearest so the
  // nearest requesting index is the one that sticks.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] last_ptr
  );
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    pick = last_ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last_ptr + IDX_W'(i);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_24.sv
// 2-to-4 decoder with enable.
//   en : decode enable; y is all zeros when low
//   a  : 2-bit index
//   y  : one-hot output, y[a] = en
module decoder_24 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign y[gi] = en && (a == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_24.sv
// Four-requester round-robin arbiter for one shared resource.
// Sequence per grant: IDLE -> GRANT (held until release) -> IDLE for at
// least one cycle, so consecutive grants are always separated by a gap.
// Optional feature macro: RR_ARB_TIMEOUT_EN -- adds a hold counter that
// forces release after MAX_HOLD grant cycles and pulses timeout.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : level request lines, bit i = requester i
//   done    : one-cycle release pulse from the current owner
//   gnt_en  : grant valid
//   gnt_idx : granted requester index (held after release)
//   gnt_oh  : one-hot grant decoded from gnt_en/gnt_idx
//   busy    : resource owned (same as gnt_en)
//   timeout : one-cycle pulse in the first cycle after a forced release
module rr_arbiter_24
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_en,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic             busy,
  output logic             timeout
);

  // Reject illegal configurations at elaboration time.
  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
      $error("rr_arbiter_24: MAX_HOLD must be 2..255 and below 2**CNT_W");
    end
  endgenerate

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic [IDX_W-1:0] last_ptr_reg, last_ptr_next;
  logic             release_req;
  logic             force_rel;

  // A done pulse and a dropped request in the same cycle are one release.
  assign release_req = done | ~req[gnt_idx_reg];

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             timeout_reg;

  // Held at zero in IDLE, so it reads 0 in the first GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  assign force_rel = (state_reg == GRANT) &&
                     (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));

  // A normal release at the limit wins, so no timeout is flagged then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= force_rel & ~release_req;
    end
  end

  assign timeout = timeout_reg;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_idx_reg  <= '0;
      last_ptr_reg <= IDX_W'(N_REQ - 1);
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      last_ptr_reg <= last_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    last_ptr_next = last_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next   = GRANT;
          gnt_idx_next = rr_pick(req, last_ptr_reg);
        end
      end
      GRANT: begin
        // No preemption: other requests are ignored until release.
        if (release_req || force_rel) begin
          state_next    = IDLE;
          last_ptr_next = gnt_idx_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_en  = (state_reg == GRANT);
  assign busy    = gnt_en;
  assign gnt_idx = gnt_idx_reg;

  decoder_24 u_dec (
    .en (gnt_en),
    .a  (gnt_idx_reg),
    .y  (gnt_oh)
  );

endmodule

// File: tb/tb_rr_arbiter_24.sv
module tb_rr_arbiter_24;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       gnt_en;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_oh;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_24 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_en  (gnt_en),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [1:0] idx;
    logic [3:0] oh;
  } vec_t;

  vec_t vecs[32];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Check every output against an expected grant; busy tracks en,
  // timeout expectation given explicitly.
  task automatic chk_all(input string tag, input logic en, input logic [1:0] idx,
                         input logic [3:0] oh, input logic to);
    chk({tag, ".gnt_en"},  8'(gnt_en),  8'(en));
    chk({tag, ".gnt_idx"}, 8'(gnt_idx), 8'(idx));
    chk({tag, ".gnt_oh"},  8'(gnt_oh),  8'(oh));
    chk({tag, ".busy"},    8'(busy),    8'(en));
    chk({tag, ".timeout"}, 8'(timeout), 8'(to));
    $display("%s: req=%b done=%b -> en=%b idx=%0d oh=%b to=%b",
             tag, req, done, gnt_en, gnt_idx, gnt_oh, timeout);
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fairness rotation from reset pointer (0,1,2,3,0,1,2,3), each grant one
    // cycle then done, gap cycle between.
    vecs[0]  = '{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[2]  = '{4'b1111, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[3]  = '{4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[4]  = '{4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[5]  = '{4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[6]  = '{4'b1111, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[7]  = '{4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000};
    vecs[8]  = '{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[9]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[11] = '{4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[12] = '{4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[13] = '{4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[14] = '{4'b1111, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[15] = '{4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000};
    // done in IDLE ignored
    vecs[16] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000};
    // Wrap: last=3, req 1001 -> 0, then 3; simultaneous done + drop
    vecs[17] = '{4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[18] = '{4'b1001, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[19] = '{4'b1001, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[20] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000};
    vecs[21] = '{4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000};
    // Single requester 2 held three cycles, no preemption by req[0]
    vecs[22] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[23] = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[24] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[25] = '{4'b0100, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[26] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    // Grant to 1, req[2] arrives, req[1] drops -> release, gap, grant 2
    vecs[27] = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[28] = '{4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[29] = '{4'b0100, 1'b0, 1'b0, 2'd1, 4'b0000};
    vecs[30] = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[31] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};

    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk_all("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    for (int i = 0; i < 32; i++) begin
      step(vecs[i].req, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].idx, vecs[i].oh, 1'b0);
    end

    // Asynchronous reset mid-grant; last_ptr must return to 3.
    step(4'b0100, 1'b0);
    chk_all("pre_rst_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    req = 4'b0000;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // With last_ptr=3 requester 1 wins over 3; a stale pointer of 2 would pick 3.
    step(4'b1010, 1'b0);
    chk_all("rst_ptr", 1'b1, 2'd1, 4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    chk_all("rst_ptr_rel", 1'b0, 2'd1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // MAX_HOLD=4: four grant cycles, forced release with timeout, regrant.
    for (int c = 1; c <= 4; c++) begin
      step(4'b0001, 1'b0);
      chk_all($sformatf("hold%0d", c), 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    step(4'b0001, 1'b0);
    chk_all("forced_rel", 1'b0, 2'd0, 4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    chk_all("regrant", 1'b1, 2'd0, 4'b0001, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step(4'b0001, 1'b0);
      chk_all($sformatf("hold_b%0d", c), 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    // done at the limit cycle: normal release, no timeout.
    step(4'b0001, 1'b1);
    chk_all("limit_done", 1'b0, 2'd0, 4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk_all("limit_done_after", 1'b0, 2'd0, 4'b0000, 1'b0);
`else
    // Without the timeout feature a grant is held indefinitely.
    for (int c = 1; c <= 8; c++) begin
      step(4'b0001, 1'b0);
      chk_all($sformatf("hold%0d", c), 1'b1, 2'd0, 4'b0001, 1'b0);
    end
    step(4'b0000, 1'b0);
    chk_all("hold_rel", 1'b0, 2'd0, 4'b0000, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
